// File: rtl/mux_shift_reg_pkg.sv
// Shared mode encodings for the mux/shift register.
// No logic; no latency; no backpressure.
package mux_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    typedef enum logic [1:0] {
        MD_HOLD = MODE_HOLD,
        MD_LOAD = MODE_LOAD,
        MD_SHL  = MODE_SHL,
        MD_SHR  = MODE_SHR
    } mode_t;

endpackage

// File: rtl/mux_shift_reg_mux_nto1.sv
// N-to-1 word selector with a range flag on sel.
// Purely combinational, zero latency; no backpressure.
module mux_nto1 #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     dout,
    output logic                 sel_valid
);

    // Out-of-range selects yield zero rather than reading past the bus.
    always_comb begin
        dout = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SEL_W'(k)) begin
                dout = d[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_valid = (32'(sel) < NCH);

endmodule

// File: rtl/mux_shift_reg.sv
// Channel-select then load/hold/shift register with load counter and sel error pulse.
// One cycle from inputs to q; en=0 stalls all state. `define ROTATE_EN makes shifts rotate.
module mux_shift_reg
    import mux_shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int SEL_W = $clog2(NCH),
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]     sel,
    input  logic [1:0]           mode,
    input  logic                 en,
    input  logic                 ser_in,
    output logic [WIDTH-1:0]     q,
    output logic                 ser_out,
    output logic                 sel_err,
    output logic [CNT_W-1:0]     load_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_q, ser_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] mux_dat;
    logic             mux_vld;
    logic             shl_in, shr_in;
    logic [WIDTH:0]   shl_ext, shr_ext;
    mode_t            mode_e;

    mux_nto1 #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_mux (
        .d         (d),
        .sel       (sel),
        .dout      (mux_dat),
        .sel_valid (mux_vld)
    );

`ifdef ROTATE_EN
    assign shl_in = q_q[WIDTH-1];
    assign shr_in = q_q[0];
`else
    assign shl_in = ser_in;
    assign shr_in = ser_in;
`endif

    // Extended vectors keep the shift expressions legal for WIDTH=1.
    assign shl_ext = {q_q, shl_in};
    assign shr_ext = {shr_in, q_q};
    assign mode_e  = mode_t'(mode);

    always_comb begin
        q_d   = q_q;
        ser_d = ser_q;
        err_d = 1'b0;
        cnt_d = cnt_q;
        if (en) begin
            case (mode_e)
                MD_LOAD: begin
                    if (mux_vld) begin
                        q_d = mux_dat;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                MD_SHL: begin
                    q_d   = shl_ext[WIDTH-1:0];
                    ser_d = q_q[WIDTH-1];
                end
                MD_SHR: begin
                    q_d   = shr_ext[WIDTH:1];
                    ser_d = q_q[0];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            ser_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            ser_q <= ser_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign q        = q_q;
    assign ser_out  = ser_q;
    assign sel_err  = err_q;
    assign load_cnt = cnt_q;

endmodule

// File: tb/tb_mux_shift_reg.sv
// Directed bench for mux_shift_reg at WIDTH=4, NCH=3, CNT_W=2.
module tb_mux_shift_reg;

    localparam int WIDTH = 4;
    localparam int NCH   = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] d;
    logic [SEL_W-1:0]     sel;
    logic [1:0]           mode;
    logic                 en;
    logic                 ser_in;
    logic [WIDTH-1:0]     q;
    logic                 ser_out;
    logic                 sel_err;
    logic [CNT_W-1:0]     load_cnt;

    int checks = 0;
    int errors = 0;

    mux_shift_reg #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .sel      (sel),
        .mode     (mode),
        .en       (en),
        .ser_in   (ser_in),
        .q        (q),
        .ser_out  (ser_out),
        .sel_err  (sel_err),
        .load_cnt (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] shl_final;
    logic [WIDTH-1:0] shr_final;

    initial begin
`ifdef ROTATE_EN
        shl_final = 4'b1001;
        shr_final = 4'b1001;
`else
        shl_final = 4'b0000;
        shr_final = 4'b1101;
`endif
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 2'b00;
        sel    = '0;
        ser_in = 1'b0;
        d      = {4'h9, 4'h5, 4'h3};
        #12;
        check("rst_q", 32'(q), 32'h0);
        check("rst_ser_out", 32'(ser_out), 32'h0);
        check("rst_sel_err", 32'(sel_err), 32'h0);
        check("rst_cnt", 32'(load_cnt), 32'h0);
        rst_n = 1'b1;
        #1;

        en = 1'b1; mode = 2'b01; sel = 2'd1;
        step();
        check("load_ch1_q", 32'(q), 32'h5);
        check("load_ch1_cnt", 32'(load_cnt), 32'd1);

        sel = 2'd0;
        step();
        check("load_ch0_q", 32'(q), 32'h3);
        check("load_ch0_cnt", 32'(load_cnt), 32'd2);

        en = 1'b0; sel = 2'd2;
        step();
        check("en0_q", 32'(q), 32'h3);
        check("en0_cnt", 32'(load_cnt), 32'd2);

        en = 1'b1; sel = 2'd3;
        step();
        check("illegal_err", 32'(sel_err), 32'h1);
        check("illegal_q", 32'(q), 32'h3);
        check("illegal_cnt", 32'(load_cnt), 32'd2);

        mode = 2'b00;
        step();
        check("hold_clears_err", 32'(sel_err), 32'h0);
        check("hold_q", 32'(q), 32'h3);

        mode = 2'b01; sel = 2'd3;
        step();
        check("b2b_err_1", 32'(sel_err), 32'h1);
        step();
        check("b2b_err_2", 32'(sel_err), 32'h1);
        mode = 2'b00;
        step();
        check("b2b_err_clear", 32'(sel_err), 32'h0);

        mode = 2'b01; sel = 2'd2;
        step();
        check("load_ch2_q", 32'(q), 32'h9);
        check("load_ch2_cnt", 32'(load_cnt), 32'd3);

        // Out-of-range sel during shifts must be ignored.
        mode = 2'b10; ser_in = 1'b0; sel = 2'd3;
        step();
        check("shl_ser_1", 32'(ser_out), 32'h1);
        check("shl_no_err", 32'(sel_err), 32'h0);
        step();
        check("shl_ser_2", 32'(ser_out), 32'h0);
        step();
        check("shl_ser_3", 32'(ser_out), 32'h0);
        step();
        check("shl_ser_4", 32'(ser_out), 32'h1);
        check("shl_final_q", 32'(q), 32'(shl_final));

        d = {4'h9, 4'h5, 4'h6};
        mode = 2'b01; sel = 2'd0;
        step();
        check("load_0110_q", 32'(q), 32'h6);
        check("cnt_saturated_4", 32'(load_cnt), 32'd3);

        mode = 2'b11; ser_in = 1'b1;
        step();
        check("shr_ser_1", 32'(ser_out), 32'h0);
        step();
        check("shr_ser_2", 32'(ser_out), 32'h1);
        check("shr_final_q", 32'(q), 32'(shr_final));

        mode = 2'b00;
        step();
        check("hold_ser_out", 32'(ser_out), 32'h1);
        check("hold_q_after_shr", 32'(q), 32'(shr_final));

        d = {4'h9, 4'hA, 4'h6};
        mode = 2'b01; sel = 2'd1;
        step();
        check("load_A_q", 32'(q), 32'hA);
        check("cnt_saturated_5", 32'(load_cnt), 32'd3);
        check("load_keeps_ser_out", 32'(ser_out), 32'h1);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 32'h0);
        check("async_rst_cnt", 32'(load_cnt), 32'd0);
        check("async_rst_ser", 32'(ser_out), 32'h0);
        #2;
        rst_n = 1'b1;

        sel = 2'd2;
        step();
        check("post_rst_q", 32'(q), 32'h9);
        check("post_rst_cnt", 32'(load_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
